music_player: RTL and testbench
===============================

MUSIC_PLAYER -- requirements
Module: music_player

Interface
REQ-001 SHALL have parameter CLKS_PER_SAMPLE, default 1134, meaning Clk cycles per audio sample (50 MHz / ~44.1 kHz).
REQ-002 SHALL have parameter DEPTH, default 80550, meaning number of words in the music ROM.
REQ-003 SHALL have parameter WIDTH, default 17, meaning sample and address width.
REQ-004 SHALL have port Clk  input  1  system clock; all state updates on rising edge.
REQ-005 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port play  input  1  level; 1 enables the sample-rate counter.
REQ-007 SHALL have port loop_en  input  1  level; 1 wraps to address 0 at end of track.
REQ-008 SHALL have port restart  input  1  single-cycle pulse; rewinds to address 0.
REQ-009 SHALL have port rom_addr  output  WIDTH  read address to the music ROM (registered-read, 1-cycle latency).
REQ-010 SHALL have port rom_data  input  WIDTH  ROM data for the address presented one edge earlier.
REQ-011 SHALL have port sample  output  WIDTH  current audio sample to the codec serializer.
REQ-012 SHALL have port sample_valid  output  1  sample holds a word not yet accepted.
REQ-013 SHALL have port sample_ready  input  1  downstream accepts sample this cycle.
REQ-014 SHALL have port track_done  output  1  one-cycle pulse when the last word is accepted with loop_en=0.
REQ-015 SHALL have port overrun  output  1  sticky flag: a sample tick was dropped.

Function
REQ-016 Tick counter SHALL count 0..CLKS_PER_SAMPLE-1 only while play=1, assert internal tick in the cycle it equals CLKS_PER_SAMPLE-1, then wrap to 0; it SHALL hold its value while play=0.
REQ-017 FSM states SHALL be IDLE, READ, CAPTURE, HOLD, STOPPED.
REQ-018 IDLE->READ on tick; READ->CAPTURE unconditionally; CAPTURE->HOLD unconditionally, loading sample<=rom_data.
REQ-019 Tick in cycle N from IDLE SHALL give sample_valid=1 from cycle N+3.
REQ-020 rom_addr SHALL equal the address register and SHALL not change in READ, CAPTURE or HOLD.
REQ-021 In HOLD, sample_valid=1 and sample SHALL be stable until a cycle with sample_ready=1 (transfer).
REQ-022 On transfer with addr<DEPTH-1: addr<=addr+1, state->IDLE.
REQ-023 On transfer with addr=DEPTH-1: addr<=0; if loop_en=1 state->IDLE; else track_done=1 next cycle, state->STOPPED.
REQ-024 STOPPED SHALL ignore ticks and SHALL exit to IDLE only on restart.
REQ-025 A tick in READ, CAPTURE or HOLD SHALL be dropped (not queued) and SHALL set overrun.
REQ-026 play falling mid-transaction SHALL not abort it; HOLD persists until transfer.
REQ-027 restart SHALL take priority over all non-reset events: addr<=0, tick counter<=0, overrun<=0, state->IDLE, sample_valid=0 next cycle.
REQ-028 restart coinciding with a transfer: the transfer counts downstream, addr->0, track_done SHALL not pulse.
REQ-029 sample_valid SHALL be 1 only in HOLD; track_done SHALL never exceed one cycle.

Reset
REQ-030 Reset SHALL force asynchronously: state IDLE, addr 0, tick counter 0, sample 0, sample_valid 0, track_done 0, overrun 0.
REQ-031 Reset asserted mid-HOLD SHALL drop the pending sample; after release playback SHALL restart at address 0.

Structure
REQ-032 Package music_pkg SHALL hold MUSIC_DEPTH (80550), MUSIC_WIDTH (17), default CLKS_PER_SAMPLE and the FSM state enum.
REQ-033 Tick counter SHALL be sub-module sample_tick_gen (ports Clk, Reset, en, clr, tick).
REQ-034 ROM instantiation SHALL be outside this block; the top level connects rom_addr/rom_data.

Verification (CLKS_PER_SAMPLE=4, DEPTH=8, ROM word k = 0x100+k)
REQ-035 play=1, sample_ready=1 -> sample 0x100..0x107 in order, one valid every 4 cycles, first valid 3 cycles after first tick.
REQ-036 loop_en=0, full run -> track_done one-cycle pulse after 0x107 accepted, no further sample_valid; restart -> 0x100 next.
REQ-037 loop_en=1, 10 samples -> 0x100..0x107, 0x100, 0x101; track_done never asserts.
REQ-038 sample_ready=0 for 10 cycles in HOLD -> sample held at same value, overrun=1, no address skip on release.
REQ-039 restart in HOLD with sample_ready=1 -> next sample 0x100, track_done=0, overrun cleared.
REQ-040 Reset mid-CAPTURE at addr 5 -> all outputs 0 immediately; next sample after release 0x100.

Source files
------------

// File: rtl/music_pkg.sv
// Shared constants and FSM state encoding for the music player.
// Defaults target a 50 MHz clock feeding a ~44.1 kHz codec from an 80550-word ROM.
package music_pkg;

    localparam int MUSIC_DEPTH           = 80550;
    localparam int MUSIC_WIDTH           = 17;
    localparam int MUSIC_CLKS_PER_SAMPLE = 1134;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPTURE,
        HOLD,
        STOPPED
    } music_state_t;

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate tick: free-running divider gated by en, one-cycle tick on the last count.
// Latency: tick is combinational from the count; clr zeroes the count on the next edge.
module sample_tick_gen #(
    parameter int CLKS_PER_SAMPLE = 1134
) (
    input  logic Clk,
    input  logic Reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_SAMPLE - 1);

    logic [CW-1:0] count;

    assign tick = en && (count == LAST);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/music_player.sv
// Streams ROM words to the codec one per sample tick; ticks arriving while a word is in flight are dropped.
// Latency: tick to sample_valid is 3 cycles; sample holds in HOLD until sample_ready.
module music_player
    import music_pkg::*;
#(
    parameter int CLKS_PER_SAMPLE = MUSIC_CLKS_PER_SAMPLE,
    parameter int DEPTH           = MUSIC_DEPTH,
    parameter int WIDTH           = MUSIC_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             play,
    input  logic             loop_en,
    input  logic             restart,
    output logic [WIDTH-1:0] rom_addr,
    input  logic [WIDTH-1:0] rom_data,
    output logic [WIDTH-1:0] sample,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic             track_done,
    output logic             overrun
);

    localparam logic [WIDTH-1:0] LAST_ADDR = WIDTH'(DEPTH - 1);

    music_state_t     state, state_nxt;
    logic [WIDTH-1:0] addr, addr_nxt;
    logic [WIDTH-1:0] sample_nxt;
    logic             done_nxt;
    logic             overrun_nxt;
    logic             tick;

    sample_tick_gen #(
        .CLKS_PER_SAMPLE(CLKS_PER_SAMPLE)
    ) u_tick (
        .Clk  (Clk),
        .Reset(Reset),
        .en   (play),
        .clr  (restart),
        .tick (tick)
    );

    assign rom_addr     = addr;
    assign sample_valid = (state == HOLD);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            addr       <= '0;
            sample     <= '0;
            track_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            addr       <= addr_nxt;
            sample     <= sample_nxt;
            track_done <= done_nxt;
            overrun    <= overrun_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        addr_nxt    = addr;
        sample_nxt  = sample;
        done_nxt    = 1'b0;
        overrun_nxt = overrun;

        if (restart) begin
            // Rewind wins over everything; a coincident transfer still counted downstream.
            state_nxt   = IDLE;
            addr_nxt    = '0;
            overrun_nxt = 1'b0;
        end else begin
            if (tick && (state == READ || state == CAPTURE || state == HOLD)) begin
                overrun_nxt = 1'b1;
            end
            case (state)
                IDLE: begin
                    if (tick) begin
                        state_nxt = READ;
                    end
                end
                READ: begin
                    state_nxt = CAPTURE;
                end
                CAPTURE: begin
                    sample_nxt = rom_data;
                    state_nxt  = HOLD;
                end
                HOLD: begin
                    if (sample_ready) begin
                        if (addr == LAST_ADDR) begin
                            addr_nxt = '0;
                            if (loop_en) begin
                                state_nxt = IDLE;
                            end else begin
                                done_nxt  = 1'b1;
                                state_nxt = STOPPED;
                            end
                        end else begin
                            addr_nxt  = addr + 1'b1;
                            state_nxt = IDLE;
                        end
                    end
                end
                STOPPED: begin
                    state_nxt = STOPPED;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_music_player.sv
// Self-checking bench: directed scenarios plus a random phase, all scored against a cycle-level behavioural model.
module tb_music_player;

    localparam int CPS = 4;
    localparam int D   = 8;
    localparam int W   = 17;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         play, loop_en, restart, sample_ready;
    logic [W-1:0] rom_addr, rom_data, sample;
    logic         sample_valid, track_done, overrun;

    int total = 0;
    int bad   = 0;

    // Model state: divider phase, current word index, word-in-flight age, stop/overrun flags.
    int m_cnt, m_addr, m_age;
    bit m_busy, m_stopped, m_ovr;
    int cyc, td_pulses;
    logic [W-1:0] acc[$];
    int acc_cyc[$];

    always #5 Clk = ~Clk;

    always @(posedge Clk) rom_data <= 17'h100 + rom_addr;

    music_player #(
        .CLKS_PER_SAMPLE(CPS),
        .DEPTH          (D),
        .WIDTH          (W)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .play        (play),
        .loop_en     (loop_en),
        .restart     (restart),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .sample      (sample),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .track_done  (track_done),
        .overrun     (overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_valid();
        return m_busy && (m_age >= 2);
    endfunction

    function automatic logic [31:0] acc_at(input int k);
        if (acc.size() > k) return 32'(acc[k]);
        return 32'hDEAD_BEEF;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_addr = 0; m_age = 0;
        m_busy = 0; m_stopped = 0; m_ovr = 0;
    endtask

    // Advance one clock (negedge to negedge), updating the model and scoring the DUT.
    task automatic cycle();
        logic         pr, prs, pp, ple, pv, tk, exp_td;
        logic [W-1:0] ps;
        bit           vb;
        pv = sample_valid; ps = sample; pr = sample_ready;
        prs = restart; pp = play; ple = loop_en;
        @(negedge Clk);
        cyc++;
        tk     = pp && (m_cnt == CPS - 1);
        exp_td = 1'b0;
        vb     = m_valid();
        if (prs) begin
            if (vb && pr) begin
                check("xfer_on_restart", 32'(ps), 32'h100 + m_addr);
                acc.push_back(ps); acc_cyc.push_back(cyc);
            end
            model_reset();
        end else begin
            if (pp) m_cnt = (m_cnt + 1) % CPS;
            if (tk && m_busy) m_ovr = 1;
            if (vb && pr) begin
                check("xfer_data", 32'(ps), 32'h100 + m_addr);
                acc.push_back(ps); acc_cyc.push_back(cyc);
                m_busy = 0;
                if (m_addr == D - 1) begin
                    m_addr = 0;
                    if (!ple) begin
                        m_stopped = 1;
                        exp_td    = 1'b1;
                    end
                end else begin
                    m_addr++;
                end
            end else if (m_busy) begin
                m_age++;
            end else if (tk && !m_stopped) begin
                m_busy = 1;
                m_age  = 0;
            end
            if (pv && !pr) check("hold_stable", 32'(sample), 32'(ps));
        end
        check("sample_valid", 32'(sample_valid), 32'(m_valid()));
        check("track_done", 32'(track_done), 32'(exp_td));
        check("overrun", 32'(overrun), 32'(m_ovr));
        check("rom_addr", 32'(rom_addr), 32'(m_addr));
        if (track_done) td_pulses++;
    endtask

    task automatic run_until_acc(input int n, input int budget, input string tag);
        int b;
        b = budget;
        while (acc.size() < n && b > 0) begin
            cycle();
            b--;
        end
        check(tag, 32'(acc.size() >= n), 32'd1);
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        cycle();
        restart = 1'b0;
    endtask

    initial begin
        int          n, vcount, a;
        logic [W-1:0] hv;
        logic [31:0] exp37 [10];
        bit          found;

        Reset = 1'b1; play = 0; loop_en = 0; restart = 0; sample_ready = 0;
        model_reset(); cyc = 0; td_pulses = 0;
        repeat (2) @(negedge Clk);
        check("rst_sample", 32'(sample), 0);
        check("rst_valid", 32'(sample_valid), 0);
        check("rst_done", 32'(track_done), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_addr", 32'(rom_addr), 0);
        Reset = 1'b0;

        // Full run, no loop: order, cadence, first-valid latency, single done pulse.
        play = 1; sample_ready = 1; loop_en = 0;
        n = 0;
        while (!sample_valid && n < 20) begin
            cycle();
            n++;
        end
        check("first_valid_latency", n, 6);
        run_until_acc(8, 60, "full_run_count");
        for (int k = 0; k < 8; k++) check("full_run_word", acc_at(k), 32'h100 + k);
        for (int k = 0; k < 7; k++)
            if (acc_cyc.size() == 8) check("full_run_spacing", acc_cyc[k+1] - acc_cyc[k], 4);
        vcount = 0;
        repeat (20) begin
            cycle();
            if (sample_valid) vcount++;
        end
        check("no_valid_after_done", vcount, 0);
        check("done_pulses", td_pulses, 1);
        pulse_restart();
        acc.delete(); acc_cyc.delete();
        run_until_acc(1, 20, "after_restart_count");
        check("after_restart_word", acc_at(0), 32'h100);

        // Looping: ten words wrap through the end without a done pulse.
        loop_en = 1; td_pulses = 0;
        pulse_restart();
        acc.delete(); acc_cyc.delete();
        exp37 = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h104,
                  32'h105, 32'h106, 32'h107, 32'h100, 32'h101};
        run_until_acc(10, 80, "loop_count");
        for (int k = 0; k < 10; k++) check("loop_word", acc_at(k), exp37[k]);
        check("loop_no_done", td_pulses, 0);

        // Backpressure: 10 stalled cycles in HOLD, then release with no skipped address.
        sample_ready = 0;
        n = 0;
        while (!sample_valid && n < 20) begin
            cycle();
            n++;
        end
        check("stall_reach_hold", 32'(sample_valid), 1);
        hv = sample; a = m_addr;
        check("stall_value", 32'(hv), 32'h100 + a);
        repeat (10) cycle();
        check("stall_held", 32'(sample), 32'(hv));
        check("stall_overrun", 32'(overrun), 1);
        sample_ready = 1;
        acc.delete(); acc_cyc.delete();
        run_until_acc(2, 30, "stall_release_count");
        check("stall_release_word", acc_at(0), 32'(hv));
        check("stall_no_skip", acc_at(1), 32'h100 + ((a + 1) % D));

        // Restart coinciding with a transfer in HOLD.
        sample_ready = 0;
        n = 0;
        while (!sample_valid && n < 20) begin
            cycle();
            n++;
        end
        check("rs_overrun_before", 32'(overrun), 1);
        sample_ready = 1;
        pulse_restart();
        check("rs_no_done", 32'(track_done), 0);
        check("rs_overrun_clear", 32'(overrun), 0);
        check("rs_valid_drop", 32'(sample_valid), 0);
        acc.delete(); acc_cyc.delete();
        run_until_acc(1, 20, "rs_next_count");
        check("rs_next_word", acc_at(0), 32'h100);

        // Asynchronous reset in CAPTURE while fetching address 5.
        found = 0; n = 0;
        while (!found && n < 200) begin
            cycle();
            n++;
            found = (m_addr == 5) && m_busy && (m_age == 1);
        end
        check("reach_capture_addr5", 32'(found), 1);
        #2 Reset = 1'b1;
        #1;
        check("async_rst_sample", 32'(sample), 0);
        check("async_rst_valid", 32'(sample_valid), 0);
        check("async_rst_addr", 32'(rom_addr), 0);
        check("async_rst_overrun", 32'(overrun), 0);
        check("async_rst_done", 32'(track_done), 0);
        @(negedge Clk);
        Reset = 1'b0;
        model_reset();
        acc.delete(); acc_cyc.delete();
        run_until_acc(1, 20, "post_rst_count");
        check("post_rst_word", acc_at(0), 32'h100);

        // Random traffic against the model.
        repeat (1500) begin
            play         = ($urandom % 8) != 0;
            sample_ready = ($urandom % 3) != 0;
            if ($urandom % 64 == 0) loop_en = ~loop_en;
            restart      = ($urandom % 97) == 0;
            cycle();
        end
        restart = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
